// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipelined control unit: opcodes, ALUOp encodings and per-stage control bundles.
// Pure declarations; no latency or backpressure of its own.
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to control-bundle decoder, plus which source registers the instruction reads.
// Latency: combinational. Backpressure: none.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       valid,
    input  logic       rd_nz,
    output ctrl_t      ctrl,
    output logic       use_rs1,
    output logic       use_rs2
);

    always_comb begin
        ctrl    = CTRL_NOP;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (valid) begin
            case (opcode)
                OPC_RTYPE: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALUOP_FUNCT;
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
                OPC_LOAD: begin
                    ctrl.memread  = 1'b1;
                    ctrl.memtoreg = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    use_rs1       = 1'b1;
                end
                OPC_IALU: begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    use_rs1       = 1'b1;
                end
                OPC_STORE: begin
                    ctrl.memwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
                OPC_BRANCH: begin
                    ctrl.branch = 1'b1;
                    ctrl.aluop  = ALUOP_BRANCH;
                    use_rs1     = 1'b1;
                    use_rs2     = 1'b1;
                end
                OPC_JAL: begin
                    ctrl.jump     = 1'b1;
                    ctrl.regwrite = 1'b1;
                end
                OPC_JALR: begin
                    ctrl.jump     = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    use_rs1       = 1'b1;
                end
                default: ;
            endcase
        end
        // x0 is never a real destination
        if (!rd_nz) begin
            ctrl.regwrite = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode, load-use stall, taken-branch squash, ID/EX-EX/MEM-MEM/WB control regs.
// Latency: 1 cycle per stage; hazard_stall/flush_if_id combinational. Backpressure: ext_stall freezes all stages.
// PIPE_CTRL_PERF_EN adds saturating stall_cnt/flush_cnt counters.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         id_opcode,
    input  logic [RA_W-1:0]    id_rs1,
    input  logic [RA_W-1:0]    id_rs2,
    input  logic [RA_W-1:0]    id_rd,
    input  logic               id_valid,
    input  logic               ext_stall,
    input  logic               ex_taken,
    output logic               hazard_stall,
    output logic               flush_if_id,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic               ex_memtoreg,
    output logic               ex_regwrite,
    output logic [RA_W-1:0]    ex_rd,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               mem_memtoreg,
    output logic               mem_regwrite,
    output logic [RA_W-1:0]    mem_rd,
    output logic               wb_memtoreg,
    output logic               wb_regwrite,
    output logic [RA_W-1:0]    wb_rd
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    ctrl_t            dec_ctrl;
    logic             use_rs1, use_rs2;
    logic             taken, haz_raw;

    ctrl_t            ex_q, ex_d;
    mem_ctrl_t        mem_q, mem_d;
    wb_ctrl_t         wb_q, wb_d;
    logic [RA_W-1:0]  ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;

    ctrl_decode u_decode (
        .opcode  (id_opcode),
        .valid   (id_valid),
        .rd_nz   (id_rd != '0),
        .ctrl    (dec_ctrl),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    assign taken   = ex_taken & (ex_q.branch | ex_q.jump);
    assign haz_raw = ex_q.memread && (ex_rd_q != '0) && id_valid &&
                     ((use_rs1 && (id_rs1 == ex_rd_q)) || (use_rs2 && (id_rs2 == ex_rd_q)));

    // The instruction in ID is squashed on a taken branch, so it cannot stall.
    assign hazard_stall = haz_raw & ~taken;
    assign flush_if_id  = taken;

    always_comb begin
        ex_d     = ex_q;
        ex_rd_d  = ex_rd_q;
        mem_d    = mem_q;
        mem_rd_d = mem_rd_q;
        wb_d     = wb_q;
        wb_rd_d  = wb_rd_q;
        if (!ext_stall) begin
            if (taken || hazard_stall) begin
                ex_d    = CTRL_NOP;
                ex_rd_d = '0;
            end else begin
                ex_d    = dec_ctrl;
                ex_rd_d = id_valid ? id_rd : '0;
            end
            mem_d    = {ex_q.memread, ex_q.memwrite, ex_q.memtoreg, ex_q.regwrite};
            mem_rd_d = ex_rd_q;
            wb_d     = {mem_q.memtoreg, mem_q.regwrite};
            wb_rd_d  = mem_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= CTRL_NOP;
            ex_rd_q  <= '0;
            mem_q    <= '0;
            mem_rd_q <= '0;
            wb_q     <= '0;
            wb_rd_q  <= '0;
        end else begin
            ex_q     <= ex_d;
            ex_rd_q  <= ex_rd_d;
            mem_q    <= mem_d;
            mem_rd_q <= mem_rd_d;
            wb_q     <= wb_d;
            wb_rd_q  <= wb_rd_d;
        end
    end

    assign ex_aluop     = ALUOP_W'(ex_q.aluop);
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;
    assign ex_memread   = ex_q.memread;
    assign ex_memwrite  = ex_q.memwrite;
    assign ex_memtoreg  = ex_q.memtoreg;
    assign ex_regwrite  = ex_q.regwrite;
    assign ex_rd        = ex_rd_q;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_memtoreg = mem_q.memtoreg;
    assign mem_regwrite = mem_q.regwrite;
    assign mem_rd       = mem_rd_q;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_rd        = wb_rd_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard_stall && !ext_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_if_id && !ext_stall && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit; with PIPE_CTRL_PERF_EN the counters are built 2 bits wide to reach saturation.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] R    = 7'b0110011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] IA   = 7'b0010011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

`ifdef PIPE_CTRL_PERF_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 32;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_valid, ext_stall, ex_taken;
    logic       hazard_stall, flush_if_id;
    logic [1:0] ex_aluop;
    logic       ex_alusrc, ex_branch, ex_jump, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
    logic       wb_memtoreg, wb_regwrite;
`ifdef PIPE_CTRL_PERF_EN
    logic [1:0] stall_cnt, flush_cnt;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.ALUOP_W(2), .RA_W(5), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_valid(id_valid), .ext_stall(ext_stall), .ex_taken(ex_taken),
        .hazard_stall(hazard_stall), .flush_if_id(flush_if_id),
        .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // {branch, jump, memread, memtoreg, memwrite, alusrc, regwrite, aluop}
    wire [8:0]  ex_vec  = {ex_branch, ex_jump, ex_memread, ex_memtoreg, ex_memwrite,
                           ex_alusrc, ex_regwrite, ex_aluop};
    wire [3:0]  mem_vec = {mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite};
    wire [1:0]  wb_vec  = {wb_memtoreg, wb_regwrite};
    wire [31:0] all_vec = {hazard_stall, flush_if_id, ex_vec, ex_rd, mem_vec, mem_rd, wb_vec, wb_rd};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic vld);
        id_opcode = opc;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_valid  = vld;
        #1;
    endtask

    task automatic bubble();
        drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ext_stall = 1'b0; ex_taken = 1'b0;
        bubble();
        #10;
        total++;
        if (all_vec !== 32'd0) $display("FAIL reset_initial: got %h want 0", all_vec);
        else passed++;
        step();
        rst_n = 1'b1;
        // fill the pipe, then reset between edges
        drive(LD, 5'd1, 5'd0, 5'd4, 1'b1); step();
        drive(R,  5'd1, 5'd2, 5'd3, 1'b1); step();
        drive(IA, 5'd1, 5'd0, 5'd2, 1'b1); step();
        total++;
        if (all_vec === 32'd0) $display("FAIL reset_prefill: got %h want nonzero", all_vec);
        else passed++;
        bubble();
        rst_n = 1'b0;
        #1;
        total++;
        if (all_vec !== 32'd0) $display("FAIL reset_midstream: got %h want 0", all_vec);
        else passed++;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_decode();
        logic [6:0] opcs [9] = '{R, LD, IA, ST, BR, JAL, JALR, 7'b1111111, R};
        logic       vlds [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [8:0] exps [9] = '{9'b000000110, 9'b001101100, 9'b000001100, 9'b000011000,
                                 9'b100000001, 9'b010000100, 9'b010001100, 9'b0, 9'b0};
        for (int i = 0; i < 9; i++) begin
            drive(opcs[i], 5'd1, 5'd2, 5'd7, vlds[i]);
            step();
            total++;
            if (ex_vec !== exps[i]) $display("FAIL decode_%0d: got %b want %b", i, ex_vec, exps[i]);
            else passed++;
        end
        bubble(); step();
    endtask

    task automatic test_back_to_back();
        drive(LD, 5'd1, 5'd0, 5'd11, 1'b1); step();
        drive(ST, 5'd1, 5'd2, 5'd0,  1'b1); step();
        drive(R,  5'd1, 5'd2, 5'd13, 1'b1); step();
        bubble();
        total++;
        if ({ex_rd, mem_rd, wb_rd} !== {5'd13, 5'd0, 5'd11})
            $display("FAIL b2b_rd: got %0d/%0d/%0d want 13/0/11", ex_rd, mem_rd, wb_rd);
        else passed++;
        total++;
        if ({mem_vec, wb_vec} !== {4'b0100, 2'b11})
            $display("FAIL b2b_memwb: got %b/%b want 0100/11", mem_vec, wb_vec);
        else passed++;
        step();
        total++;
        if ({mem_vec, mem_rd, wb_vec, wb_rd} !== {4'b0001, 5'd13, 2'b00, 5'd0})
            $display("FAIL b2b_drain: got %b/%0d/%b/%0d want 0001/13/00/0", mem_vec, mem_rd, wb_vec, wb_rd);
        else passed++;
        step(); step();
    endtask

    task automatic test_load_use();
        drive(LD, 5'd1, 5'd0, 5'd5, 1'b1); step();
        drive(R, 5'd5, 5'd2, 5'd6, 1'b1);
        total++;
        if ({hazard_stall, flush_if_id} !== 2'b10)
            $display("FAIL lu_stall: got %b want 10", {hazard_stall, flush_if_id});
        else passed++;
        step();
        total++;
        if ({ex_vec, ex_rd, mem_memread, mem_rd} !== {9'b0, 5'd0, 1'b1, 5'd5})
            $display("FAIL lu_bubble: got %b rd %0d mem %b/%0d want 0/0/1/5", ex_vec, ex_rd, mem_memread, mem_rd);
        else passed++;
        total++;
        if (hazard_stall !== 1'b0) $display("FAIL lu_one_cycle: got %b want 0", hazard_stall);
        else passed++;
        step();
        total++;
        if ({ex_vec, ex_rd} !== {9'b000000110, 5'd6})
            $display("FAIL lu_add_in_ex: got %b rd %0d want 000000110 rd 6", ex_vec, ex_rd);
        else passed++;
        // rs2 of a store matches
        drive(LD, 5'd1, 5'd0, 5'd9, 1'b1); step();
        drive(ST, 5'd3, 5'd9, 5'd0, 1'b1);
        total++;
        if (hazard_stall !== 1'b1) $display("FAIL lu_store_rs2: got %b want 1", hazard_stall);
        else passed++;
        // jal reads no register even if its field matches
        drive(JAL, 5'd9, 5'd9, 5'd1, 1'b1);
        total++;
        if (hazard_stall !== 1'b0) $display("FAIL lu_jal_norse: got %b want 0", hazard_stall);
        else passed++;
        // invalid ID never stalls
        drive(R, 5'd9, 5'd9, 5'd1, 1'b0);
        total++;
        if (hazard_stall !== 1'b0) $display("FAIL lu_invalid: got %b want 0", hazard_stall);
        else passed++;
        bubble(); step(); step();
    endtask

    task automatic test_x0();
        drive(LD, 5'd1, 5'd0, 5'd0, 1'b1); step();
        total++;
        if (ex_vec !== 9'b001101000) $display("FAIL x0_load_vec: got %b want 001101000", ex_vec);
        else passed++;
        drive(R, 5'd0, 5'd0, 5'd6, 1'b1);
        total++;
        if (hazard_stall !== 1'b0) $display("FAIL x0_nostall: got %b want 0", hazard_stall);
        else passed++;
        drive(IA, 5'd1, 5'd0, 5'd0, 1'b1); step();
        total++;
        if (ex_regwrite !== 1'b0) $display("FAIL x0_addi: got %b want 0", ex_regwrite);
        else passed++;
        bubble(); step();
    endtask

    task automatic test_flush();
        drive(BR, 5'd1, 5'd2, 5'd0, 1'b1); step();
        ex_taken = 1'b1;
        drive(R, 5'd1, 5'd2, 5'd8, 1'b1);
        total++;
        if ({hazard_stall, flush_if_id} !== 2'b01)
            $display("FAIL flush_beq: got %b want 01", {hazard_stall, flush_if_id});
        else passed++;
        step();
        total++;
        if ({ex_vec, ex_rd} !== 14'd0) $display("FAIL flush_bubble: got %b rd %0d want 0", ex_vec, ex_rd);
        else passed++;
        // taken with a non-branch in EX is ignored
        total++;
        if (flush_if_id !== 1'b0) $display("FAIL flush_unqual: got %b want 0", flush_if_id);
        else passed++;
        ex_taken = 1'b0;
        drive(LD, 5'd1, 5'd0, 5'd5, 1'b1); step();
        ex_taken = 1'b1;
        drive(R, 5'd5, 5'd2, 5'd6, 1'b1);
        total++;
        if ({hazard_stall, flush_if_id} !== 2'b10)
            $display("FAIL flush_load_taken: got %b want 10", {hazard_stall, flush_if_id});
        else passed++;
        ex_taken = 1'b0;
        bubble(); step(); step();
    endtask

    task automatic test_ext_stall();
        drive(R,   5'd1, 5'd2, 5'd3, 1'b1); step();
        drive(IA,  5'd1, 5'd0, 5'd4, 1'b1); step();
        drive(JAL, 5'd0, 5'd0, 5'd1, 1'b1); step();
        ext_stall = 1'b1;
        ex_taken  = 1'b1;
        drive(R, 5'd1, 5'd2, 5'd9, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({ex_vec, ex_rd, mem_vec, mem_rd, wb_vec, wb_rd} !==
                {9'b010000100, 5'd1, 4'b0001, 5'd4, 2'b01, 5'd3})
                $display("FAIL stall_hold_%0d: got %b %0d %b %0d %b %0d", c, ex_vec, ex_rd,
                         mem_vec, mem_rd, wb_vec, wb_rd);
            else passed++;
        end
        ext_stall = 1'b0;
        #1;
        total++;
        if (flush_if_id !== 1'b1) $display("FAIL stall_release_flush: got %b want 1", flush_if_id);
        else passed++;
        step();
        total++;
        if ({ex_vec, ex_rd, mem_rd, wb_rd} !== {9'b0, 5'd0, 5'd1, 5'd4})
            $display("FAIL stall_release_adv: got %b %0d %0d %0d want 0 0 1 4", ex_vec, ex_rd, mem_rd, wb_rd);
        else passed++;
        ex_taken = 1'b0;
        bubble(); step(); step();
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        total++;
        if ({stall_cnt, flush_cnt} !== 4'd0) $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            drive(LD, 5'd1, 5'd0, 5'd5, 1'b1); step();
            drive(R, 5'd5, 5'd2, 5'd6, 1'b1); step();
            bubble(); step();
        end
        for (int k = 0; k < 2; k++) begin
            drive(BR, 5'd1, 5'd2, 5'd0, 1'b1); step();
            ex_taken = 1'b1; bubble(); step();
            ex_taken = 1'b0;
        end
        total++;
        if ({stall_cnt, flush_cnt} !== {2'd3, 2'd2}) $display("FAIL perf_counts: got %0d/%0d want 3/2", stall_cnt, flush_cnt);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            drive(LD, 5'd1, 5'd0, 5'd5, 1'b1); step();
            drive(R, 5'd5, 5'd2, 5'd6, 1'b1); step();
            bubble(); step();
        end
        total++;
        if (stall_cnt !== 2'd3) $display("FAIL perf_saturate: got %0d want 3", stall_cnt);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_load_use();
        test_x0();
        test_flush();
        test_ext_stall();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
